seg_display_scan: RTL and testbench

// - Output-side counterpart to the keypad/button Input block.
// - Takes the three code digits, cursor position and lock status that Input produces.
// - Drives a 4-digit multiplexed 7-segment display (digits 0-2 = code, digit 3 = status).
// - Scans one digit per refresh tick, blinks the digit being edited, inserts a 1-cycle blank between digits.

---
 rtl/seg_display_scan.sv | 125 ++++++++++++
 tb/tb_seg_display_scan.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Four-digit multiplexed 7-segment scanner: three code digits plus a lock-status
// glyph, one digit per refresh slot, a one-cycle dark gap between digits, and cursor blink.
module seg_display_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_HALF = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Value0,
  input  logic [3:0] Value1,
  input  logic [3:0] Value2,
  input  logic [1:0] Cursor,
  input  logic       EditEn,
  input  logic       Lock,
  output logic [6:0] Seg,
  output logic [3:0] An
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic          dead_q, dead_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic          tick;
  logic [3:0]    cur_val;
  logic [6:0]    digit_pat;
  logic [6:0]    pat;

  assign tick = (scan_cnt_q == SW'(SCAN_DIV - 1));

  always_comb begin
    cur_val = Value0;
    case (idx_q)
      2'd0:    cur_val = Value0;
      2'd1:    cur_val = Value1;
      2'd2:    cur_val = Value2;
      default: cur_val = Value0;
    endcase
  end

  always_comb begin
    digit_pat = 7'h40;
    case (cur_val)
      4'd0:    digit_pat = 7'h3F;
      4'd1:    digit_pat = 7'h06;
      4'd2:    digit_pat = 7'h5B;
      4'd3:    digit_pat = 7'h4F;
      4'd4:    digit_pat = 7'h66;
      4'd5:    digit_pat = 7'h6D;
      4'd6:    digit_pat = 7'h7D;
      4'd7:    digit_pat = 7'h07;
      4'd8:    digit_pat = 7'h7F;
      4'd9:    digit_pat = 7'h6F;
      default: digit_pat = 7'h40;
    endcase
  end

  // Cursor value 3 can never equal a code-digit index, so the idx==3 check excludes it.
  always_comb begin
    pat = 7'h00;
    if (idx_q == 2'd3) begin
      pat = Lock ? 7'h38 : 7'h3E;
    end else if (EditEn && (Cursor == idx_q) && phase_q) begin
      pat = 7'h00;
    end else begin
      pat = digit_pat;
    end
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q + SW'(1);
    blink_cnt_d = blink_cnt_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    dead_d      = dead_q;
    seg_d       = pat;
    an_d        = an_q;
    if (tick) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
      an_d       = 4'b1111;
      seg_d      = 7'h00;
      dead_d     = 1'b1;
      if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else if (dead_q) begin
      an_d   = ~(4'b0001 << idx_q);
      dead_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      idx_q       <= 2'd3;
      phase_q     <= 1'b0;
      dead_q      <= 1'b0;
      seg_q       <= 7'h00;
      an_q        <= 4'b1111;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      dead_q      <= dead_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign Seg = seg_q;
  assign An  = an_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: per-frame digit table, hand-written timing corners,
// and randomized inputs checked against an edge-count based reference model.
module tb_seg_display_scan;

  localparam int SD = 4;
  localparam int BH = 2;

  logic       clk;
  logic       rst;
  logic [3:0] v0, v1, v2;
  logic [1:0] cursor;
  logic       edit_en;
  logic       lock;
  logic [6:0] seg;
  logic [3:0] an;

  int n_vec;
  int n_err;
  int e;  // rising edges since reset release

  seg_display_scan #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .Value0(v0), .Value1(v1), .Value2(v2),
    .Cursor(cursor), .EditEn(edit_en), .Lock(lock), .Seg(seg), .An(an)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v0, v1, v2;
    logic       lock;
    logic [6:0] exp_seg [4];
  } frame_vec_t;

  frame_vec_t tbl [4];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
    end
  endtask

  // reference model: outputs after edge number k, derived from tick counts
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] lut [10];
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (v < 10) ? lut[v] : 7'h40;
  endfunction

  function automatic void model(input int k, output logic [3:0] ea, output logic [6:0] es);
    int ticks, digit;
    bit phase;
    logic [3:0] vals [3];
    vals  = '{v0, v1, v2};
    ticks = k / SD;
    digit = (3 + ticks) % 4;
    phase = ((ticks / BH) % 2) == 1;
    ea = 4'b1111;
    es = 7'h00;
    if (k % SD != 0) begin
      if (ticks > 0) ea[digit] = 1'b0;
      if (digit == 3) es = lock ? 7'h38 : 7'h3E;
      else if (edit_en && cursor == 2'(digit) && phase) es = 7'h00;
      else es = glyph(vals[digit]);
    end
  endfunction

  // driver tasks
  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    model(e + 1, ea, es);
    @(posedge clk);
    #1;
    e++;
    check("model_an", {4'h0, an}, {4'h0, ea});
    check("model_seg", {1'b0, seg}, {1'b0, es});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_seg", {1'b0, seg}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    e = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; e = 0;
    rst = 1'b0;
    v0 = 4'd1; v1 = 4'd0; v2 = 4'd0; cursor = 2'd3; edit_en = 1'b0; lock = 1'b1;

    tbl[0] = '{v0: 4'd1,  v1: 4'd2, v2: 4'd3,  lock: 1'b1, exp_seg: '{7'h06, 7'h5B, 7'h4F, 7'h38}};
    tbl[1] = '{v0: 4'd4,  v1: 4'd5, v2: 4'd6,  lock: 1'b1, exp_seg: '{7'h66, 7'h6D, 7'h7D, 7'h38}};
    tbl[2] = '{v0: 4'd12, v1: 4'd0, v2: 4'd9,  lock: 1'b0, exp_seg: '{7'h40, 7'h3F, 7'h6F, 7'h3E}};
    tbl[3] = '{v0: 4'd7,  v1: 4'd8, v2: 4'd15, lock: 1'b0, exp_seg: '{7'h07, 7'h7F, 7'h40, 7'h3E}};

    // reset release timing: first tick at edge 4, digit 0 lit at edge 5
    do_reset();
    for (int i = 0; i < 3; i++) step();
    step();
    check("rel_e4_an", {4'h0, an}, 8'h0F);
    step();
    check("rel_e5_an", {4'h0, an}, 8'h0E);
    check("rel_e5_seg", {1'b0, seg}, 8'h06);

    // table-driven frames: each lit slot shows the table glyph
    for (int t = 0; t < 4; t++) begin
      v0 = tbl[t].v0; v1 = tbl[t].v1; v2 = tbl[t].v2; lock = tbl[t].lock;
      do_reset();
      for (int c = 0; c < 2 * 4 * SD + 1; c++) begin
        step();
        if (e % SD == 1 && e > SD) begin
          int d;
          logic [3:0] exp_an;
          d = ((e / SD) + 3) % 4;
          exp_an = 4'b1111;
          exp_an[d] = 1'b0;
          check("tbl_an", {4'h0, an}, {4'h0, exp_an});
          check("tbl_seg", {1'b0, seg}, {1'b0, tbl[t].exp_seg[d]});
        end
      end
    end

    // mid-slot value change shows up on the next edge without waiting for a tick
    v0 = 4'd3; lock = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("mid_pre_seg", {1'b0, seg}, 8'h4F);
    v0 = 4'd7;
    step();
    check("mid_post_seg", {1'b0, seg}, 8'h07);
    check("mid_post_an", {4'h0, an}, 8'h0E);

    // blink: digit 1 lit at edge 9 is in blink phase 1
    v1 = 4'd5; edit_en = 1'b1; cursor = 2'd1;
    do_reset();
    for (int i = 0; i < 9; i++) step();
    check("blink_an", {4'h0, an}, 8'h0D);
    check("blink_seg", {1'b0, seg}, 8'h00);
    cursor = 2'd3;
    step();
    check("blink_none_seg", {1'b0, seg}, 8'h6D);
    edit_en = 1'b0;
    cursor = 2'd1;
    step();
    check("blink_off_seg", {1'b0, seg}, 8'h6D);

    // async reset mid-frame, then scan restarts at digit 0
    for (int i = 0; i < 6; i++) step();
    v0 = 4'd2;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("rst_restart_an", {4'h0, an}, 8'h0E);
    check("rst_restart_seg", {1'b0, seg}, 8'h5B);

    // randomized inputs against the reference model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        v0 = 4'($urandom_range(0, 15));
        v1 = 4'($urandom_range(0, 15));
        v2 = 4'($urandom_range(0, 15));
        cursor  = 2'($urandom_range(0, 3));
        edit_en = 1'($urandom_range(0, 1));
        lock    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
